// File: rtl/decim_pkg.sv
// Shared definitions for the decimation sequencing controller:
// FSM state encoding, rate-code width/default and default sample width.
package decim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int              RATE_W       = 3;
  localparam logic [RATE_W-1:0] RATE_DEFAULT = 3'b001;
  localparam int              DW_DEFAULT   = 16;

endpackage

// File: rtl/decim_frame_cnt.sv
// Logger frame counter: counts accepted output samples, wraps at FRAME_LEN,
// and flags when the next accepted sample is sample 0 of a frame.
module decim_frame_cnt
  import decim_pkg::*;
#(
  parameter int FRAME_LEN = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  output logic frame_start
);

  localparam int CW = $clog2(FRAME_LEN);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear has priority so that every restart begins a fresh frame
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (adv)
      cnt_d = (cnt_q == CW'(FRAME_LEN - 1)) ? '0 : cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign frame_start = (cnt_q == '0);

endmodule

// File: rtl/decim_ctrl.sv
// Sequencing controller for the single-channel decimator: owns decimator
// reset/rate, gates ADC strobes, applies rate changes at output-sample
// boundaries and frames decimated output for the logger buffer.
// Optional watchdog enabled by defining DECIM_TIMEOUT_EN.
module decim_ctrl
  import decim_pkg::*;
#(
  parameter int DW            = DW_DEFAULT,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int FRAME_LEN     = 256,
  parameter int TIMEOUT       = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [2:0]    cfg_rate,
  input  logic          cfg_wr,
  output logic          cfg_ack,
  input  logic          adc_drdy,
  input  logic [DW-1:0] adc_data,
  output logic          dec_reset,
  output logic [2:0]    dec_rate,
  output logic          dec_drdy,
  output logic [DW-1:0] dec_datain,
  input  logic          dec_data_rdy,
  input  logic [DW-1:0] dec_dataout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_frame_start,
  output logic [7:0]    drop_cnt,
  output logic          busy,
  output logic          timeout
);

  localparam int PMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [RATE_W-1:0] rate_q, rate_d, pend_rate_q, pend_rate_d;
  logic              pend_q, pend_d, ack_q, ack_d;
  logic              drdy_q, drdy_d, ov_q, ov_d, ofs_q, ofs_d;
  logic [DW-1:0]     din_q, din_d, od_q, od_d;
  logic [7:0]        drop_q, drop_d;
  logic              run, entry, tmo_hit, frame_start;

  assign run = (state_q == ST_RUN);

`ifdef DECIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          tmo_q, tmo_d;

  assign tmo_hit = run && !dec_data_rdy && (to_cnt_q == TW'(TIMEOUT - 1));

  // watchdog: clocks in RUN since the last decimator output strobe
  always_comb begin
    to_cnt_d = '0;
    if (run && !dec_data_rdy) to_cnt_d = to_cnt_q + 1'b1;
    tmo_d = tmo_q | tmo_hit;
  end

  // watchdog registers; the flag is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign timeout        = 1'b0;
`endif

  // sequencing FSM: next state and phase counter for RESTART/SETTLE timing
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_RESTART;
      ST_RESTART: begin
        if (ph_q == PW'(RST_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          ph_d    = '0;
        end else ph_d = ph_q + 1'b1;
      end
      ST_SETTLE: begin
        if (ph_q == PW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          ph_d    = '0;
        end else ph_d = ph_q + 1'b1;
      end
      ST_RUN: if ((dec_data_rdy && pend_q) || tmo_hit) state_d = ST_RESTART;
      default: state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
    entry = (state_d == ST_RESTART) && (state_q != ST_RESTART);
    if (entry) ph_d = '0;
  end

  // rate handling: a write in the entry cycle is applied and acked on that entry
  always_comb begin
    pend_rate_d = pend_rate_q;
    pend_d      = pend_q;
    rate_d      = rate_q;
    ack_d       = 1'b0;
    if (cfg_wr) begin
      pend_rate_d = cfg_rate;
      pend_d      = 1'b1;
    end
    if (entry) begin
      rate_d = pend_rate_d;
      ack_d  = pend_d;
      pend_d = 1'b0;
    end
  end

  // input gating, drop counting and output registration
  always_comb begin
    drdy_d = run && adc_drdy;
    din_d  = (run && adc_drdy) ? adc_data : din_q;
    drop_d = (!run && adc_drdy && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    ov_d   = run && dec_data_rdy;
    od_d   = (run && dec_data_rdy) ? dec_dataout : od_q;
    ofs_d  = run && dec_data_rdy && frame_start;
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      rate_q      <= RATE_DEFAULT;
      pend_rate_q <= RATE_DEFAULT;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      drdy_q      <= 1'b0;
      din_q       <= '0;
      drop_q      <= '0;
      ov_q        <= 1'b0;
      od_q        <= '0;
      ofs_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      rate_q      <= rate_d;
      pend_rate_q <= pend_rate_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      drdy_q      <= drdy_d;
      din_q       <= din_d;
      drop_q      <= drop_d;
      ov_q        <= ov_d;
      od_q        <= od_d;
      ofs_q       <= ofs_d;
    end
  end

  decim_frame_cnt #(.FRAME_LEN(FRAME_LEN)) u_frame_cnt (
    .clk         (clk),
    .reset       (reset),
    .clr         (!run),
    .adv         (run && dec_data_rdy),
    .frame_start (frame_start)
  );

  assign dec_reset       = (state_q == ST_IDLE) || (state_q == ST_RESTART);
  assign busy            = (state_q != ST_IDLE);
  assign dec_rate        = rate_q;
  assign cfg_ack         = ack_q;
  assign dec_drdy        = drdy_q;
  assign dec_datain      = din_q;
  assign out_valid       = ov_q;
  assign out_data        = od_q;
  assign out_frame_start = ofs_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_decim_ctrl.sv
// Self-checking bench for decim_ctrl: start-up vector table, hand-written
// rate-change / timeout / enable sequences and a randomized RUN phase
// checked against a sample-count model.
module tb_decim_ctrl;

  localparam int DW = 16;
  localparam int FL = 256;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_wr, cfg_ack, adc_drdy, dec_reset, dec_drdy;
  logic [2:0]    cfg_rate, dec_rate;
  logic [DW-1:0] adc_data, dec_datain, dec_dataout, out_data;
  logic          dec_data_rdy, out_valid, out_frame_start, busy, timeout;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  decim_ctrl #(.DW(DW), .RST_CYCLES(4), .SETTLE_CYCLES(8), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_rate(cfg_rate), .cfg_wr(cfg_wr),
    .cfg_ack(cfg_ack), .adc_drdy(adc_drdy), .adc_data(adc_data), .dec_reset(dec_reset),
    .dec_rate(dec_rate), .dec_drdy(dec_drdy), .dec_datain(dec_datain),
    .dec_data_rdy(dec_data_rdy), .dec_dataout(dec_dataout), .out_valid(out_valid),
    .out_data(out_data), .out_frame_start(out_frame_start), .drop_cnt(drop_cnt),
    .busy(busy), .timeout(timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // after the first RESTART cycle: 3 more RESTART + 8 SETTLE + 1 into RUN
  task automatic wait_restart(output int acks);
    acks = 0;
    repeat (12) begin
      tick();
      if (cfg_ack) acks++;
    end
  endtask

  typedef struct {
    logic          en;
    logic          drdy;
    logic [DW-1:0] data;
    logic          x_rst;
    logic          x_fwd;
    logic [DW-1:0] x_din;
    logic [7:0]    x_drop;
  } vec_t;

  vec_t tv[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int            acks;
    int            nout;
    int            n;
    logic [DW-1:0] d, ad, exp_din;
    logic          a, r;

    // start-up table: enable, 4 cycles reset, 8 settle, then RUN
    for (int i = 0; i < 16; i++) begin
      tv[i].en     = 1'b1;
      tv[i].drdy   = 1'b0;
      tv[i].data   = 16'h0055;
      tv[i].x_rst  = (i < 4);
      tv[i].x_fwd  = 1'b0;
      tv[i].x_din  = (i >= 13) ? 16'd10 : 16'd0;
      tv[i].x_drop = (i < 1) ? 8'd0 : (i < 5) ? 8'd1 : (i < 9) ? 8'd2 : 8'd3;
    end
    tv[1].drdy  = 1'b1;
    tv[5].drdy  = 1'b1;
    tv[9].drdy  = 1'b1;
    tv[13].drdy = 1'b1;
    tv[13].data = 16'd10;
    tv[13].x_fwd = 1'b1;

    reset = 1'b1; enable = 1'b0; cfg_wr = 1'b0; cfg_rate = 3'd0;
    adc_drdy = 1'b0; adc_data = '0; dec_data_rdy = 1'b0; dec_dataout = '0;
    tick(); tick();
    chk("rst dec_reset", 32'(dec_reset), 1);
    chk("rst dec_rate", 32'(dec_rate), 1);
    chk("rst dec_drdy", 32'(dec_drdy), 0);
    chk("rst dec_datain", 32'(dec_datain), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_frame_start", 32'(out_frame_start), 0);
    chk("rst cfg_ack", 32'(cfg_ack), 0);
    chk("rst drop_cnt", 32'(drop_cnt), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst timeout", 32'(timeout), 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      enable = tv[i].en; adc_drdy = tv[i].drdy; adc_data = tv[i].data;
      tick();
      chk($sformatf("vec%0d dec_reset", i), 32'(dec_reset), 32'(tv[i].x_rst));
      chk($sformatf("vec%0d busy", i), 32'(busy), 1);
      chk($sformatf("vec%0d dec_drdy", i), 32'(dec_drdy), 32'(tv[i].x_fwd));
      chk($sformatf("vec%0d dec_datain", i), 32'(dec_datain), 32'(tv[i].x_din));
      chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(tv[i].x_drop));
    end
    adc_drdy = 1'b0;
    nout = 0;

    // rate change waits for the next output sample boundary
    dec_data_rdy = 1'b1; dec_dataout = 16'd1; tick();
    chk("t3 first fs", 32'(out_frame_start), 1); nout++;
    dec_dataout = 16'd2; tick();
    chk("t3 second fs", 32'(out_frame_start), 0); nout++;
    dec_data_rdy = 1'b0;
    cfg_wr = 1'b1; cfg_rate = 3'b011; tick(); cfg_wr = 1'b0;
    chk("t3 rate held", 32'(dec_rate), 1);
    chk("t3 no early ack", 32'(cfg_ack), 0);
    repeat (5) tick();
    chk("t3 still running", 32'(dec_reset), 0);
    chk("t3 rate still held", 32'(dec_rate), 1);
    dec_data_rdy = 1'b1; dec_dataout = 16'hBEEF; tick(); dec_data_rdy = 1'b0;
    chk("t3 boundary valid", 32'(out_valid), 1);
    chk("t3 boundary data", 32'(out_data), 32'hBEEF);
    chk("t3 boundary fs", 32'(out_frame_start), 0);
    chk("t3 rate applied", 32'(dec_rate), 3);
    chk("t3 ack", 32'(cfg_ack), 1);
    chk("t3 restart", 32'(dec_reset), 1);
    wait_restart(acks);
    chk("t3 single ack", 32'(acks), 0);
    chk("t3 back in run", 32'(dec_reset), 0);
    nout = 0;
    dec_data_rdy = 1'b1; dec_dataout = 16'd7; tick(); dec_data_rdy = 1'b0;
    chk("t3 fs after restart", 32'(out_frame_start), 1);
    chk("t3 data after restart", 32'(out_data), 7);
    nout++;

    // two writes before the boundary: last wins, one ack
    cfg_wr = 1'b1; cfg_rate = 3'b010; tick();
    cfg_rate = 3'b100; tick(); cfg_wr = 1'b0; tick();
    chk("t4 rate held", 32'(dec_rate), 3);
    dec_data_rdy = 1'b1; dec_dataout = 16'h1234; tick(); dec_data_rdy = 1'b0;
    chk("t4 rate last wins", 32'(dec_rate), 4);
    chk("t4 ack", 32'(cfg_ack), 1);
    chk("t4 boundary fs", 32'(out_frame_start), 0);
    wait_restart(acks);
    chk("t4 single ack", 32'(acks), 0);
    nout = 0;

    // 513 back-to-back output samples: frame starts at 0, 256, 512
    for (int i = 0; i < 513; i++) begin
      d = 16'($urandom);
      dec_data_rdy = 1'b1; dec_dataout = d; tick();
      chk($sformatf("t5 valid %0d", i), 32'(out_valid), 1);
      chk($sformatf("t5 data %0d", i), 32'(out_data), 32'(d));
      chk($sformatf("t5 fs %0d", i), 32'(out_frame_start), 32'((nout % FL) == 0));
      nout++;
    end
    dec_data_rdy = 1'b0;

    // randomized RUN traffic against the sample-count model
    exp_din = 16'd10;
    for (int i = 0; i < 300; i++) begin
      a = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      ad = 16'($urandom); d = 16'($urandom);
      adc_drdy = a; adc_data = ad; dec_data_rdy = r; dec_dataout = d;
      tick();
      if (a) exp_din = ad;
      chk($sformatf("rnd dec_drdy %0d", i), 32'(dec_drdy), 32'(a));
      chk($sformatf("rnd dec_datain %0d", i), 32'(dec_datain), 32'(exp_din));
      chk($sformatf("rnd out_valid %0d", i), 32'(out_valid), 32'(r));
      if (r) begin
        chk($sformatf("rnd out_data %0d", i), 32'(out_data), 32'(d));
        chk($sformatf("rnd fs %0d", i), 32'(out_frame_start), 32'((nout % FL) == 0));
        nout++;
      end
    end
    adc_drdy = 1'b0; dec_data_rdy = 1'b0;
    chk("rnd no drops in run", 32'(drop_cnt), 3);

    // watchdog / enable dropped mid-SETTLE
    dec_data_rdy = 1'b1; tick(); dec_data_rdy = 1'b0;
`ifdef DECIM_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 300) begin tick(); n++; end
    chk("t6 timeout set", 32'(timeout), 1);
    chk("t6 timeout cycle", 32'(n), TO);
    chk("t6 timeout restart", 32'(dec_reset), 1);
    repeat (6) tick();
`else
    n = 0;
    repeat (150) begin tick(); n++; end
    chk("t6 timeout tied", 32'(timeout), 0);
    chk("t6 no restart", 32'(dec_reset), 0);
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    repeat (6) tick();
`endif
    chk("t6 mid settle", 32'(dec_reset), 0);
    chk("t6 mid settle busy", 32'(busy), 1);
    enable = 1'b0; tick();
    chk("t6 idle dec_reset", 32'(dec_reset), 1);
    chk("t6 idle busy", 32'(busy), 0);
`ifdef DECIM_TIMEOUT_EN
    chk("t6 timeout sticky", 32'(timeout), 1);
`endif

    // IDLE: outputs ignored, pending rate retained, ack on entry
    dec_data_rdy = 1'b1; dec_dataout = 16'h7777; tick(); dec_data_rdy = 1'b0;
    chk("idle out ignored", 32'(out_valid), 0);
    cfg_wr = 1'b1; cfg_rate = 3'd5; tick(); cfg_wr = 1'b0;
    chk("idle rate retained", 32'(dec_rate), 4);
    chk("idle no ack", 32'(cfg_ack), 0);
    tick();
    enable = 1'b1; cfg_wr = 1'b1; cfg_rate = 3'd6; tick(); cfg_wr = 1'b0;
    chk("entry write applied", 32'(dec_rate), 6);
    chk("entry write ack", 32'(cfg_ack), 1);
    wait_restart(acks);
    chk("entry single ack", 32'(acks), 0);
    dec_data_rdy = 1'b1; dec_dataout = 16'h0042; tick(); dec_data_rdy = 1'b0;
    chk("re-enable fs", 32'(out_frame_start), 1);
    chk("re-enable data", 32'(out_data), 32'h42);

    // drop counter saturates
    enable = 1'b0; tick();
    adc_drdy = 1'b1;
    repeat (300) tick();
    adc_drdy = 1'b0;
    chk("drop saturate", 32'(drop_cnt), 255);
    chk("drop none fwd", 32'(dec_drdy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decim_ctrl.md
Name: decim_ctrl

Overview:
Sequencing controller for the single-channel decimation datapath (cu_decimation) in the FPGA logger. It does four things:
- Owns the decimator's reset and rate inputs.
- Gates ADC data-ready strobes into the decimator.
- Applies host rate changes only at an output-sample boundary.
- Frames decimated output for the downstream logger buffer.

It sits between the ADC interface and the decimator on the input side, and between the decimator and the logger FIFO on the output side.

Parameters:
DW, 16, sample width (ADC and decimator data).
RST_CYCLES, 4, cycles dec_reset is held during a (re)start.
SETTLE_CYCLES, 8, idle cycles after dec_reset before strobes are forwarded.
FRAME_LEN, 256, decimated samples per logger frame (power of two not required, >=2).
TIMEOUT, 65535, watchdog limit in clocks (used only with DECIM_TIMEOUT_EN).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  level; 1 = acquisition running.
cfg_rate  in  3  requested decimation rate code.
cfg_wr  in  1  one-cycle strobe; latches cfg_rate.
cfg_ack  out  1  one-cycle pulse when the latched rate is applied to dec_rate.
adc_drdy  in  1  one-cycle ADC sample strobe.
adc_data  in  DW  ADC sample; valid with adc_drdy.
dec_reset  out  1  reset to the decimator.
dec_rate  out  3  rate to the decimator.
dec_drdy  out  1  forwarded strobe, one cycle.
dec_datain  out  DW  forwarded sample.
dec_data_rdy  in  1  decimator output strobe.
dec_dataout  in  DW  decimator output sample.
out_valid  out  1  one-cycle output strobe.
out_data  out  DW  output sample.
out_frame_start  out  1  high with the out_valid that carries sample 0 of a frame.
drop_cnt  out  8  saturating count of adc_drdy strobes not forwarded.
busy  out  1  high in every state except IDLE.
timeout  out  1  sticky watchdog flag (tied to 0 without DECIM_TIMEOUT_EN).

Behaviour:
- Reset values:
  - dec_reset=1, dec_rate=3'b001, dec_drdy=0, dec_datain=0.
  - out_valid=0, out_data=0, out_frame_start=0.
  - cfg_ack=0, drop_cnt=0, busy=0, timeout=0.
  - Pending-rate register = 3'b001, pending flag clear, frame counter = 0, state = IDLE.
- States:
  - IDLE: dec_reset=1. Moves to RESTART when enable=1.
  - RESTART: dec_reset=1 for exactly RST_CYCLES cycles. On entry, dec_rate loads the pending rate; if the pending flag is set, cfg_ack pulses on the entry cycle and the flag clears. Then goes to SETTLE.
  - SETTLE: dec_reset=0 for SETTLE_CYCLES cycles. Then goes to RUN.
  - RUN: adc_drdy is registered onto dec_drdy and dec_datain, one-cycle latency.
- enable=0 in any state: go to IDLE on the next cycle. The frame counter clears. The pending rate is retained.
- cfg_wr: latches cfg_rate into the pending register and sets the pending flag, in any state.
  - If cfg_wr arrives again before the rate is applied, the last write wins and only one cfg_ack is issued.
  - If cfg_wr coincides with a restart entry, the new value is taken and acked on that entry.
- Rate change in RUN: leave RUN for RESTART on the cycle dec_data_rdy is seen with the pending flag set. That output sample is still passed through.
- Drops: an adc_drdy seen in any state other than RUN is dropped and drop_cnt increments, saturating at 255. drop_cnt clears only on reset.
- Output path:
  - dec_data_rdy registers onto out_valid and out_data, one-cycle latency. Accepted in RUN only; ignored elsewhere.
  - out_frame_start=1 when the frame counter is 0. The counter increments per out_valid and wraps FRAME_LEN-1 -> 0.
  - Every restart clears the counter, so the first sample after any restart is a frame start.
- Simultaneous adc_drdy and dec_data_rdy: both are handled in the same cycle.

Optional Feature:
DECIM_TIMEOUT_EN:
- When defined: in RUN, a counter counts clocks since the last dec_data_rdy (it starts at RUN entry). On reaching TIMEOUT, timeout is set (sticky until reset) and the FSM goes to RESTART. The counter clears on dec_data_rdy and outside RUN.
- When undefined: there is no counter, and timeout is tied to 0.

Decomposition:
- Shared package decim_pkg holds:
  - The FSM state encoding (IDLE, RESTART, SETTLE, RUN).
  - The rate-code width (3) and default rate constant (3'b001).
  - The DW default.
- One natural sub-module: decim_frame_cnt (frame counter plus out_frame_start generation).

Test Plan:
1. Reset, then enable=1 -> dec_reset high exactly 4 cycles, low for 8, then the first adc_drdy (adc_data=16'd10) appears on dec_drdy/dec_datain=10 one cycle later.
2. adc_drdy pulses during RESTART/SETTLE (3 pulses) -> no dec_drdy, drop_cnt=3; 300 further drops -> drop_cnt=255.
3. In RUN, cfg_wr with cfg_rate=3'b011 -> no change until the next dec_data_rdy. That sample is output, then RESTART, dec_rate=3, one cfg_ack, and the next out_valid has out_frame_start=1.
4. Two cfg_wr (3'b010 then 3'b100) before the boundary -> dec_rate=4, a single cfg_ack.
5. 513 dec_data_rdy strobes with FRAME_LEN=256 -> out_frame_start on samples 0, 256 and 512 only; out_data equals dec_dataout delayed by one cycle.
6. With DECIM_TIMEOUT_EN and TIMEOUT=100, no dec_data_rdy in RUN -> timeout=1 at cycle 100, then RESTART; enable=0 mid-SETTLE -> IDLE next cycle, dec_reset=1.
